// File: rtl/pixel_window_buffer.sv
// pixel_window_buffer
// Holds the most recent DEPTH rows of pixels and presents them as one window,
// either row-major or transposed (column-major), to the interpolation filters.
//
// Handshakes: a row is accepted on a rising edge where in_valid & in_ready;
// a window is consumed on a rising edge where win_valid & win_ready.
// Producers hold in_valid/in_row until accepted; in_ready never depends on
// in_valid, and win_valid never depends on win_ready.
module pixel_window_buffer #(
    parameter  int PIX_W   = 8,
    parameter  int ROW_PIX = 8,
    parameter  int DEPTH   = 15,
    parameter  int CNT_W   = 16,
    localparam int ROW_W   = ROW_PIX * PIX_W,
    localparam int WIN_W   = DEPTH * ROW_W,
    localparam int FILL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset_L,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ROW_W-1:0]  in_row,
    input  logic              flush,
    input  logic              transpose,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [WIN_W-1:0]  win_data,
    output logic [FILL_W-1:0] fill_cnt,
    output logic [CNT_W-1:0]  win_count,
    output logic [1:0]        state_dbg_o
);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_READY = 2'd1,
        ST_SPENT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ROW_W-1:0]   rows_q [DEPTH];
    logic               accept;

    // A row enters storage only on a real accept; flush discards it.
    assign accept = in_valid & in_ready;

    // Row storage: row 0 is the oldest; new rows enter at the top and push the oldest out.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < DEPTH; i++) rows_q[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) rows_q[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < DEPTH - 1; i++) rows_q[i] <= rows_q[i+1];
            rows_q[DEPTH-1] <= in_row;
        end
    end

    // State, fill level and window counter registers.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_FILL;
            fill_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            count_q <= count_d;
        end
    end

    // Next-state and handshake outputs; a held window blocks new rows until consumed.
    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        count_d   = count_q;
        in_ready  = 1'b1;
        win_valid = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (in_valid) begin
                    fill_d = fill_q + 1'b1;
                    if (fill_q == FILL_W'(DEPTH - 1)) state_d = ST_READY;
                end
            end
            ST_READY: begin
                win_valid = 1'b1;
                in_ready  = win_ready;
                if (win_ready) begin
                    count_d = count_q + 1'b1;
                    if (!in_valid) state_d = ST_SPENT;
                end
            end
            ST_SPENT: begin
                if (in_valid) state_d = ST_READY;
            end
            default: state_d = ST_FILL;
        endcase
        if (flush) begin
            state_d = ST_FILL;
            fill_d  = '0;
            count_d = '0;
        end
    end

    // Output slot p holds either row-major pixel (p/ROW_PIX, p%ROW_PIX)
    // or transposed pixel (row p%DEPTH, column p/DEPTH).
    for (genvar p = 0; p < DEPTH * ROW_PIX; p++) begin : g_pix
        localparam int RM_R = p / ROW_PIX;
        localparam int RM_C = p % ROW_PIX;
        localparam int TR_R = p % DEPTH;
        localparam int TR_C = p / DEPTH;
        assign win_data[p*PIX_W +: PIX_W] = transpose ? rows_q[TR_R][TR_C*PIX_W +: PIX_W]
                                                      : rows_q[RM_R][RM_C*PIX_W +: PIX_W];
    end

    assign fill_cnt    = fill_q;
    assign win_count   = count_q;
    assign state_dbg_o = state_q;

endmodule
